color_scan_classifier: RTL and testbench
========================================

# color_scan_classifier

Parametrised successor to the single-channel colour detector. The block drives the TCS3200-style filter select lines and counts `cs_out` edges over a configurable gate window for each of the green, red and blue filters. It then classifies the scan as red, green, blue or white and debounces the result over N consecutive scans. It sits between the colour sensor pins and the line-following/pick-place controller, running entirely in the `clk_1MHz` domain.

## Interface
- `WINDOW_CYCLES`, 4000: clock cycles per filter gate window.
- `SETTLE_CYCLES`, 8: cycles at the start of each window during which edges are ignored (filter settling). Must be less than `WINDOW_CYCLES`.
- `CNT_W`, 16: width of the edge counters and `freq_*` outputs.
- `WHITE_TH`, 1599: threshold compared against the white-test sum. A scan is white if the sum is ≤ `WHITE_TH`.
- `CONFIRM_N`, 2: consecutive identical classifications (1..15) required before `color`/`white` update.
- `clk_1MHz`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable. Level-sensitive.
- `cs_out`  in  1  sensor frequency output. Asynchronous to `clk_1MHz`.
- `filter`  out  2  S2/S3 select: red 2'b00, blue 2'b01, green 2'b11.
- `color`  out  3  confirmed colour: red 3'b100, green 3'b010, blue 3'b001, none 3'b000.
- `white`  out  1  confirmed class is white.
- `sample_valid`  out  1  one-cycle pulse per completed scan.
- `freq_r`, `freq_g`, `freq_b`  out  CNT_W  edge counts of the last completed scan.

## Operation
- **Input conditioning:** `cs_out` passes through a 2-flop synchroniser, then a third flop for edge detection.
  - An edge is counted when `sync2 & ~sync3`.
  - `cs_out` high and low times must each be ≥ 2 clock cycles. Faster input is undefined.
- **FSM states:** IDLE, GREEN, RED, BLUE, DECIDE.
- **IDLE:** `filter`=2'b11. Moves to GREEN when `en`=1.
- **GREEN → RED → BLUE:** each state lasts exactly `WINDOW_CYCLES` cycles.
  - The window counter and that channel's edge counter clear on window entry.
  - Edges are counted only when window count ≥ `SETTLE_CYCLES`.
  - Counters saturate at 2^CNT_W−1; they never wrap.
  - `filter` shows the state's code for the whole window.
- **DECIDE:** lasts 1 cycle, with `filter`=2'b11.
  - Latches `freq_*` and pulses `sample_valid`.
  - Classifies the scan and updates the debouncer.
  - Then goes to GREEN if `en`=1, otherwise to IDLE.
- **`en` deasserted mid-scan:** the current scan completes, including its DECIDE, then the FSM stops in IDLE.
- **Classification:** checked in priority order, first match wins.
  - White: sum of the three pairwise absolute differences, computed at CNT_W+2 bits, is ≤ `WHITE_TH`.
  - Green: G ≥ R and G ≥ B.
  - Red: R ≥ B.
  - Blue: otherwise.
- **Debouncer:**
  - Holds a candidate class and a match count that saturates at `CONFIRM_N`.
  - Same class as the candidate: the count increments. Different class: the candidate is replaced and the count resets to 1.
  - When the count equals `CONFIRM_N`, the outputs take the candidate: `white`=1 for white, otherwise `white`=0 with `color` set to the one-hot code. `color` for white is set per Configuration.
  - With `CONFIRM_N`=1, the outputs follow every scan.
- **Reset:** any time `rst_n`=0, mid-scan included, the block immediately returns to these values.
  - State IDLE, `filter`=2'b11.
  - `color`=0, `white`=0, `sample_valid`=0, `freq_*`=0.
  - Candidate cleared and match count = 0.

## Timing
- Scan period is 3·`WINDOW_CYCLES`+1 cycles: 12001 at defaults.
- The first GREEN cycle is the cycle after `en` is sampled high in IDLE.
- `sample_valid` is high exactly 1 cycle, the cycle after the last BLUE window cycle.
- `freq_*`, `color` and `white` change on the same clock edge that raises `sample_valid`.
- Edge-count latency is 3 cycles from the `cs_out` rising edge. Edges arriving during settle or across a window boundary are attributed by the state when detected.
- Back-to-back scans have no gap beyond DECIDE.

## Configuration
- `COLOR_WHITE_HOLD_EN` defined: a confirmed white sets `white`=1 and leaves `color` at its previous value, so the last colour is held over the white arena.
- Not defined: a confirmed white sets `white`=1 and `color`=3'b000.

## Test plan
All scenarios use `WINDOW_CYCLES`=100, `SETTLE_CYCLES`=4, `CNT_W`=16, `WHITE_TH`=3, `CONFIRM_N`=2 unless noted.
- **Reset/sequence:** assert `rst_n`=0 → all outputs at reset values. Release with `en`=1 → `filter` is 11 for 100 cycles, then 00 for 100, then 01 for 100; `sample_valid` pulses on cycle 301.
- **Red debounce:** `cs_out` period 4 under red, 10 under green, 8 under blue → `freq_r`=24±1, `freq_g`=10±1, `freq_b`=12±1. Scan 1 leaves `color`=0; scan 2 sets `color`=3'b100.
- **White, both builds:** after a confirmed red, apply period 5 on all filters for 2 scans → `white`=1. `color` stays 3'b100 with `COLOR_WHITE_HOLD_EN`; `color`=3'b000 without it.
- **Saturation:** `CNT_W`=4, period 2 on all filters → `freq_*`=15, no wrap.
- **Alternation:** red-dominant and blue-dominant scans alternate for 6 scans → `color` never leaves 3'b000; 6 `sample_valid` pulses.
- **Stop/reset mid-scan:** drop `en` during RED → exactly one more `sample_valid`, then IDLE with `filter`=11. Pulse `rst_n` low during BLUE → reset values on the same cycle, with no `sample_valid`.

Source files
------------

// File: rtl/color_scan_classifier.sv
// TCS3200-style colour scanner: gates cs_out edges per filter, classifies each scan, debounces the result.
// Optional build macro COLOR_WHITE_HOLD_EN keeps the last colour on color while white is confirmed.
module color_scan_classifier #(
    parameter int WINDOW_CYCLES = 4000,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16,
    parameter int WHITE_TH      = 1599,
    parameter int CONFIRM_N     = 2
) (
    input  logic             clk_1MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cs_out,
    output logic [1:0]       filter,
    output logic [2:0]       color,
    output logic             white,
    output logic             sample_valid,
    output logic [CNT_W-1:0] freq_r,
    output logic [CNT_W-1:0] freq_g,
    output logic [CNT_W-1:0] freq_b
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int SUM_W = CNT_W + 2;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] SETTLE   = WIN_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       CONF     = 4'(CONFIRM_N);

    typedef enum logic [2:0] {S_IDLE, S_GREEN, S_RED, S_BLUE, S_DECIDE} state_t;

    state_t           state, state_next;
    logic [WIN_W-1:0] win_cnt;
    logic             win_last, in_window, decide_now;
    logic             sync1, sync2, sync3, edge_det, gate;
    logic [CNT_W-1:0] cnt_g, cnt_r, cnt_b, g_nxt, r_nxt, b_nxt;
    logic [SUM_W-1:0] gx, rx, bx, d_gr, d_rb, d_gb, diff_sum;
    logic [3:0]       cls, cand, match, match_nxt;

    // Synchroniser plus one extra flop for rising-edge detection.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= cs_out;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_det   = sync2 & ~sync3;
    assign in_window  = (state == S_GREEN) || (state == S_RED) || (state == S_BLUE);
    assign win_last   = in_window && (win_cnt == WIN_LAST);
    assign decide_now = (state == S_BLUE) && win_last;

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_next;
            win_cnt <= (in_window && !win_last) ? win_cnt + WIN_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (en) state_next = S_GREEN;
            S_GREEN:  if (win_last) state_next = S_RED;
            S_RED:    if (win_last) state_next = S_BLUE;
            S_BLUE:   if (win_last) state_next = S_DECIDE;
            S_DECIDE: state_next = en ? S_GREEN : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        filter       = 2'b11;
        sample_valid = 1'b0;
        unique case (state)
            S_RED:    filter = 2'b00;
            S_BLUE:   filter = 2'b01;
            S_DECIDE: sample_valid = 1'b1;
            default:  filter = 2'b11;
        endcase
    end

    // Saturating edge counts including this cycle's edge, so DECIDE sees the last window cycle.
    always_comb begin
        gate  = edge_det && (win_cnt >= SETTLE);
        g_nxt = cnt_g;
        r_nxt = cnt_r;
        b_nxt = cnt_b;
        if (gate && state == S_GREEN && cnt_g != CNT_MAX) g_nxt = cnt_g + CNT_W'(1);
        if (gate && state == S_RED   && cnt_r != CNT_MAX) r_nxt = cnt_r + CNT_W'(1);
        if (gate && state == S_BLUE  && cnt_b != CNT_MAX) b_nxt = cnt_b + CNT_W'(1);
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_g <= '0;
            cnt_r <= '0;
            cnt_b <= '0;
        end else begin
            cnt_g <= (state_next == S_GREEN && state != S_GREEN) ? '0 : g_nxt;
            cnt_r <= (state_next == S_RED   && state != S_RED)   ? '0 : r_nxt;
            cnt_b <= (state_next == S_BLUE  && state != S_BLUE)  ? '0 : b_nxt;
        end
    end

    // cls is one-hot {white, red, green, blue}; the low three bits double as the colour code.
    always_comb begin
        gx       = SUM_W'(g_nxt);
        rx       = SUM_W'(r_nxt);
        bx       = SUM_W'(b_nxt);
        d_gr     = (gx >= rx) ? gx - rx : rx - gx;
        d_rb     = (rx >= bx) ? rx - bx : bx - rx;
        d_gb     = (gx >= bx) ? gx - bx : bx - gx;
        diff_sum = d_gr + d_rb + d_gb;
        if (diff_sum <= SUM_W'(WHITE_TH))  cls = 4'b1000;
        else if (gx >= rx && gx >= bx)     cls = 4'b0010;
        else if (rx >= bx)                 cls = 4'b0100;
        else                               cls = 4'b0001;
        if (cls == cand) match_nxt = (match == CONF) ? match : match + 4'd1;
        else             match_nxt = 4'd1;
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            freq_r <= '0;
            freq_g <= '0;
            freq_b <= '0;
            cand   <= '0;
            match  <= '0;
            color  <= 3'b000;
            white  <= 1'b0;
        end else if (decide_now) begin
            freq_r <= r_nxt;
            freq_g <= g_nxt;
            freq_b <= b_nxt;
            cand   <= cls;
            match  <= match_nxt;
            if (match_nxt == CONF) begin
                if (cls[3]) begin
                    white <= 1'b1;
`ifdef COLOR_WHITE_HOLD_EN
                    color <= color;
`else
                    color <= 3'b000;
`endif
                end else begin
                    white <= 1'b0;
                    color <= cls[2:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_color_scan_classifier.sv
// Bench for color_scan_classifier: directed scan table, hand-written corner sequences and
// randomised scans, all checked against an edge-timestamp reference model.
module tb_color_scan_classifier;

    localparam int W   = 100;
    localparam int SET = 4;
    localparam int TH  = 3;
    localparam int N   = 2;
`ifdef COLOR_WHITE_HOLD_EN
    localparam logic [2:0] WHITE_COLOR = 3'b100;
`else
    localparam logic [2:0] WHITE_COLOR = 3'b000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, cs_out;
    logic [1:0]  filter, sat_filter;
    logic [2:0]  color, sat_color;
    logic        white, sample_valid, sat_white, sat_sv;
    logic [15:0] freq_r, freq_g, freq_b;
    logic [3:0]  sat_fr, sat_fg, sat_fb;

    color_scan_classifier #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(SET), .CNT_W(16),
                            .WHITE_TH(TH), .CONFIRM_N(N)) dut (
        .clk_1MHz(clk), .rst_n(rst_n), .en(en), .cs_out(cs_out),
        .filter(filter), .color(color), .white(white), .sample_valid(sample_valid),
        .freq_r(freq_r), .freq_g(freq_g), .freq_b(freq_b));

    color_scan_classifier #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(SET), .CNT_W(4),
                            .WHITE_TH(TH), .CONFIRM_N(N)) dut_sat (
        .clk_1MHz(clk), .rst_n(rst_n), .en(en), .cs_out(cs_out),
        .filter(sat_filter), .color(sat_color), .white(sat_white), .sample_valid(sat_sv),
        .freq_r(sat_fr), .freq_g(sat_fg), .freq_b(sat_fb));

    typedef struct {
        bit         rst_before;
        int         hg, lg, hr, lr, hb, lb;
        logic [2:0] exp_color;
        logic       exp_white;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rst_req, en_req;

    // Reference model: scan schedule, detected-edge timestamps, per-instance class history.
    bit         m_idle = 1'b1;
    int         m_start = 0;
    bit         m_decide = 1'b0;
    int         det_q[$];
    int         hist0[$];
    int         hist1[$];
    logic [2:0] e_color[2];
    logic       e_white[2];
    int         e_f[2][3];

    int hi[3], lo[3];
    bit jit = 1'b0;
    int seg_left = 0;
    bit level = 1'b0, prev_cs = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Channel of cycle c: 0 green, 1 red, 2 blue, 3 idle/decide.
    function automatic int chan(int c);
        int off;
        if (m_idle) return 3;
        off = c - m_start;
        if (off < 0 || off >= 3 * W) return 3;
        return off / W;
    endfunction

    function automatic logic [1:0] chan_filter(int ch);
        case (ch)
            1:       return 2'b00;
            2:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic int absd(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // 0 white, 1 green, 2 red, 3 blue
    function automatic int classify(int g, int r, int b);
        if (absd(g, r) + absd(r, b) + absd(g, b) <= TH) return 0;
        if (g >= r && g >= b) return 1;
        if (r >= b) return 2;
        return 3;
    endfunction

    function automatic int min15(int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic apply_confirm(input int k, input int cls);
        int h[$];
        bit same;
        if (k == 0) h = hist0; else h = hist1;
        h.push_back(cls);
        if (h.size() > N) void'(h.pop_front());
        if (h.size() == N) begin
            same = 1'b1;
            foreach (h[i]) if (h[i] != h[0]) same = 1'b0;
            if (same) begin
                if (cls == 0) begin
                    e_white[k] = 1'b1;
`ifndef COLOR_WHITE_HOLD_EN
                    e_color[k] = 3'b000;
`endif
                end else begin
                    e_white[k] = 1'b0;
                    e_color[k] = (cls == 1) ? 3'b010 : (cls == 2) ? 3'b100 : 3'b001;
                end
            end
        end
        if (k == 0) hist0 = h; else hist1 = h;
    endtask

    task automatic model_reset();
        det_q.delete();
        hist0.delete();
        hist1.delete();
        for (int k = 0; k < 2; k++) begin
            e_color[k] = 3'b000;
            e_white[k] = 1'b0;
            for (int j = 0; j < 3; j++) e_f[k][j] = 0;
        end
    endtask

    task automatic model_decide();
        int c[3];
        int q[$];
        c = '{0, 0, 0};
        foreach (det_q[i]) begin
            int off;
            off = det_q[i] - m_start;
            for (int w = 0; w < 3; w++)
                if (off >= w * W + SET && off <= w * W + W - 1) c[w]++;
        end
        foreach (det_q[i]) if (det_q[i] > cyc) q.push_back(det_q[i]);
        det_q = q;
        e_f[0][0] = c[1];
        e_f[0][1] = c[0];
        e_f[0][2] = c[2];
        e_f[1][0] = min15(c[1]);
        e_f[1][1] = min15(c[0]);
        e_f[1][2] = min15(c[2]);
        apply_confirm(0, classify(c[0], c[1], c[2]));
        apply_confirm(1, classify(min15(c[0]), min15(c[1]), min15(c[2])));
    endtask

    task automatic drive_cs();
        int ch;
        if (!rst_req) begin
            cs_out   = 1'b0;
            prev_cs  = 1'b0;
            level    = 1'b0;
            seg_left = 0;
        end else begin
            ch = chan(cyc + 1);
            if (ch == 3) ch = 0;
            if (seg_left == 0) begin
                level    = ~level;
                seg_left = level ? hi[ch] : lo[ch];
                if (jit) seg_left += $urandom_range(0, 2);
            end
            seg_left--;
            cs_out = level;
            if (level && !prev_cs) det_q.push_back(cyc + 2);
            prev_cs = level;
        end
    endtask

    // One clock: check outputs of this cycle, drive inputs, advance the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        m_decide = !m_idle && (cyc - m_start == 3 * W);
        if (m_decide) model_decide();
        chk("ctl", {filter, sample_valid, white, color},
            {chan_filter(chan(cyc)), m_decide, e_white[0], e_color[0]});
        chk("freq", {freq_r, freq_g, freq_b},
            {16'(e_f[0][0]), 16'(e_f[0][1]), 16'(e_f[0][2])});
        chk("sat_ctl", {sat_filter, sat_sv, sat_white, sat_color},
            {chan_filter(chan(cyc)), m_decide, e_white[1], e_color[1]});
        chk("sat_freq", {sat_fr, sat_fg, sat_fb},
            {4'(e_f[1][0]), 4'(e_f[1][1]), 4'(e_f[1][2])});
        rst_n = rst_req;
        en    = en_req;
        if (!rst_req) begin
            model_reset();
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (en_req) begin
                m_idle  = 1'b0;
                m_start = cyc + 1;
            end
        end else if (m_decide) begin
            if (en_req) m_start = cyc + 1;
            else        m_idle  = 1'b1;
        end
        drive_cs();
    endtask

    task automatic set_cfg(input int hg, lg, hr, lr, hb, lb);
        hi[0] = hg; lo[0] = lg;
        hi[1] = hr; lo[1] = lr;
        hi[2] = hb; lo[2] = lb;
    endtask

    task automatic wait_decide(input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_decide && n < limit);
        chk("decide_reached", m_decide, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_filter"}, filter, 2'b11);
        chk({tag, "_sv"}, sample_valid, 1'b0);
        chk({tag, "_color"}, color, 3'b000);
        chk({tag, "_white"}, white, 1'b0);
        chk({tag, "_freq"}, {freq_r, freq_g, freq_b}, 48'h0);
        chk({tag, "_sat_freq"}, {sat_fr, sat_fg, sat_fb}, 12'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   n, sv_cnt, r, drop, dur;

        tbl[0]  = '{1'b1, 5, 5, 2, 2, 4, 4, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 5, 5, 2, 2, 4, 4, 3'b100, 1'b0};
        tbl[2]  = '{1'b0, 2, 3, 2, 3, 2, 3, 3'b100, 1'b0};
        tbl[3]  = '{1'b0, 2, 3, 2, 3, 2, 3, WHITE_COLOR, 1'b1};
        tbl[4]  = '{1'b1, 5, 5, 2, 2, 4, 4, 3'b000, 1'b0};
        tbl[5]  = '{1'b0, 5, 5, 4, 4, 2, 2, 3'b000, 1'b0};
        tbl[6]  = '{1'b0, 5, 5, 2, 2, 4, 4, 3'b000, 1'b0};
        tbl[7]  = '{1'b0, 5, 5, 4, 4, 2, 2, 3'b000, 1'b0};
        tbl[8]  = '{1'b0, 5, 5, 2, 2, 4, 4, 3'b000, 1'b0};
        tbl[9]  = '{1'b0, 5, 5, 4, 4, 2, 2, 3'b000, 1'b0};
        tbl[10] = '{1'b0, 2, 2, 5, 5, 4, 4, 3'b000, 1'b0};
        tbl[11] = '{1'b0, 2, 2, 5, 5, 4, 4, 3'b010, 1'b0};

        // Clock/reset
        rst_n   = 1'b0;
        en      = 1'b0;
        cs_out  = 1'b0;
        rst_req = 1'b0;
        en_req  = 1'b1;
        model_reset();
        set_cfg(5, 5, 2, 2, 4, 4);
        repeat (3) step();
        check_reset_values("reset");

        // First scan: sample_valid 301 cycles after release with en high
        rst_req = 1'b1;
        step();
        r = cyc;
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 400);
        chk("first_sv_cycle", cyc - r, 301);

        // Directed scan table
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst_before) begin
                rst_req = 1'b0;
                repeat (3) step();
                rst_req = 1'b1;
            end
            set_cfg(tbl[i].hg, tbl[i].lg, tbl[i].hr, tbl[i].lr, tbl[i].hb, tbl[i].lb);
            wait_decide(800);
            chk($sformatf("tbl%0d_color", i), color, tbl[i].exp_color);
            chk($sformatf("tbl%0d_white", i), white, tbl[i].exp_white);
        end

        // Drop en during RED: one more sample_valid, then idle
        repeat (150) step();
        en_req = 1'b0;
        sv_cnt = 0;
        repeat (700) begin
            step();
            if (sample_valid) sv_cnt++;
        end
        chk("stop_sv_count", sv_cnt, 1);
        chk("stop_filter", filter, 2'b11);

        // Reset pulse during BLUE: reset values in the same cycle
        en_req = 1'b1;
        repeat (250) step();
        rst_req = 1'b0;
        step();
        #1;
        check_reset_values("midrst");
        sv_cnt = 0;
        repeat (5) begin
            step();
            if (sample_valid) sv_cnt++;
        end
        chk("midrst_no_sv", sv_cnt, 0);
        rst_req = 1'b1;

        // Randomised scans with jittered waveforms and occasional en drops
        jit = 1'b1;
        for (int s = 0; s < 15; s++) begin
            set_cfg($urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12),
                    $urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12));
            drop = $urandom_range(0, 400);
            dur  = $urandom_range(1, 40);
            n    = 0;
            do begin
                if (n == drop) en_req = 1'b0;
                if (n == drop + dur) en_req = 1'b1;
                step();
                n++;
            end while (!m_decide && n < 1200);
            chk("rand_decide", m_decide, 1'b1);
            en_req = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
